// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold / shift right / shift left / parallel load, optional rotate,
// plus a burst controller that performs a programmed number of shifts under start/busy/done.
module univ_shift_reg #(
  parameter int N  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    mode,
  input  logic          rotate,
  input  logic          SI_R,
  input  logic          SI_L,
  input  logic [N-1:0]  D,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic [N-1:0]  Q,
  output logic          SO_R,
  output logic          SO_L,
  output logic          busy,
  output logic          done
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t        state_q;
  logic [N-1:0]  q_q, q_d;
  logic [LW-1:0] cnt_q;
  logic          dir_left_q;
  logic          rot_q;
  logic          busy_q;
  logic          done_q;
  logic          accept;

  function automatic logic [N-1:0] shift_f(input logic [N-1:0] cur, input logic left,
                                           input logic rot, input logic si_r, input logic si_l);
    if (left) return {cur[N-2:0], (rot ? cur[N-1] : si_l)};
    else      return {(rot ? cur[0] : si_r), cur[N-1:1]};
  endfunction

  assign accept = (state_q == S_IDLE) && start && ((mode == 2'b01) || (mode == 2'b10));

  // The acceptance cycle itself holds Q; shifting starts on the following edge.
  always_comb begin
    q_d = q_q;
    if (state_q == S_BURST) begin
      q_d = shift_f(q_q, dir_left_q, rot_q, SI_R, SI_L);
    end else if (!accept) begin
      case (mode)
        2'b01:   q_d = shift_f(q_q, 1'b0, rotate, SI_R, SI_L);
        2'b10:   q_d = shift_f(q_q, 1'b1, rotate, SI_R, SI_L);
        2'b11:   q_d = D;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
      rot_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      q_q <= q_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            dir_left_q <= mode[1];
            rot_q      <= rotate;
            cnt_q      <= len;
            if (len != '0) begin
              state_q <= S_BURST;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_BURST: begin
          cnt_q <= cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign SO_R = q_q[0];
  assign SO_L = q_q[N-1];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

A parametrised universal shift register that generalises the team's right-shift SISO block. It supports:
- hold, right shift, left shift and parallel load;
- an optional rotate mode instead of serial fill;
- serial outputs at both ends and a full parallel output.

A burst controller runs a programmed number of back-to-back shifts under a start/busy/done handshake. This lets serialiser and delay-line users request "shift k places" without cycle-counting themselves.

## Interface
Parameters:
- `N`, 8: register width in bits (N ≥ 2).
- `LW`, 4: width of the burst length field. Legal burst lengths are 0..2^LW−1.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `mode`, in, 2: operation select.
  - 00: hold.
  - 01: shift right.
  - 10: shift left.
  - 11: parallel load.
- `rotate`, in, 1: 1 = wrap the bit shifted out back into the vacated end; 0 = fill from the serial input.
- `SI_R`, in, 1: serial input that enters `Q[N-1]` on a right shift.
- `SI_L`, in, 1: serial input that enters `Q[0]` on a left shift.
- `D`, in, N: parallel load data.
- `start`, in, 1: request a burst.
- `len`, in, LW: number of shifts in the burst.
- `Q`, out, N: register contents.
- `SO_R`, out, 1: equals `Q[0]` (right-shift serial out).
- `SO_L`, out, 1: equals `Q[N-1]` (left-shift serial out).
- `busy`, out, 1: burst in progress.
- `done`, out, 1: one-cycle pulse at burst completion.

## Operation
- **Next-value rules** for Q, given a direction and a rotate setting:
  - Right shift: `Q <= {fill, Q[N-1:1]}`, where fill = `Q[0]` if rotating, otherwise `SI_R`.
  - Left shift: `Q <= {Q[N-2:0], fill}`, where fill = `Q[N-1]` if rotating, otherwise `SI_L`.
- **FSM states:** IDLE and BURST.
- **IDLE behaviour:** Q follows `mode` every cycle using the rules above, with `rotate` sampled live. Mode 11 loads `D`.
- **Burst acceptance:** `start` is accepted only in IDLE, and only when `mode` is 01 or 10.
  - `start` with mode 00 or 11 is ignored, and the normal mode action still applies.
- **Acceptance cycle:**
  - Q holds; no shift happens in this cycle.
  - Direction comes from `mode`.
  - `rotate` and `len` are latched into internal registers.
  - If `len` ≠ 0: go to BURST with count = `len`.
  - If `len` = 0: stay in IDLE and pulse `done` on the next cycle.
- **BURST behaviour:**
  - One shift per cycle in the latched direction, using the latched rotate setting.
  - Serial inputs are sampled live each cycle.
  - `mode`, `D`, `rotate` and `start` are ignored.
  - The count decrements after each shift. After the shift that brings the count to 0, return to IDLE.
- **Burst lengths:** any `len` up to 2^LW−1 is legal, including `len` > N. With rotate, a burst of `len` = N returns the original value.
- **Reset:**
  - Q = 0, `busy` = 0, `done` = 0, state = IDLE, count = 0.
  - Reset asserted mid-burst aborts the burst immediately. No `done` is generated afterwards.

## Timing
- Q, `SO_R` and `SO_L` update one cycle after a mode is applied. Single-operation latency is 1 clock.
- All outputs are registered or direct register taps; no combinational path from inputs to outputs.
- **Burst with `len` = L > 0, start accepted at edge T0:**
  - `busy` = 1 from T0 through T_L, falling at T_L.
  - Shifts occur at edges T1..T_L.
  - `done` = 1 for exactly the cycle after T_L, falling at T_L+1.
- **Burst with `len` = 0:** `busy` never rises; `done` rises at T0 and falls at T1.
- **Back-to-back bursts:** a new `start` may be accepted in the cycle `done` is high. State is IDLE, so there is no dead cycle beyond the acceptance cycle.
- **SISO equivalence:** with `mode` = 01 and `rotate` = 0 held in IDLE, `SO_R` reproduces `SI_R` delayed by N cycles.

## Test plan
All scenarios use N = 8, LW = 4.
1. **Reset:** assert `reset_n` = 0 asynchronously, mid-cycle, with Q = 0xFF → Q = 0x00, `busy` = 0 and `done` = 0 immediately, without waiting for a clock edge.
2. **Load and shift:** load 0xA5 (mode 11), then right shift with `SI_R` = 1 → Q = 0xD2. Then left shift with `SI_L` = 0 → Q = 0xA4. `SO_R` and `SO_L` track `Q[0]` and `Q[7]`.
3. **Rotate:** load 0x81, right shift with `rotate` = 1 → Q = 0xC0. Load 0x81, left shift with `rotate` = 1 → Q = 0x03. Serial inputs have no effect.
4. **Burst:** load 0x0F, then `start` with mode 10, `len` = 3, `SI_L` = 1 → `busy` high for 3 cycles, Q = 0x7F when `busy` falls, `done` high for exactly 1 cycle. A second `start` while `busy` is ignored.
5. **Edge bursts:**
   - `len` = 0 → `done` pulse the next cycle, Q unchanged, `busy` stays 0.
   - Rotate burst with `len` = 8 on 0x5A → Q = 0x5A at `done`.
6. **Reset mid-burst:** `len` = 10, reset after the 4th shift → Q = 0, `busy` = 0, and no `done` in the following 20 cycles. A later burst behaves normally.
